// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID skid stage.
package if_id_pkg;

   localparam int unsigned XLEN_DEF = 64;
   localparam int unsigned ILEN_DEF = 32;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [ILEN_DEF-1:0] inst;
   } entry_t;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID stage.
// slave: the stage itself; master: the surrounding fetch/decode logic.
interface if_id_skid_stage_if #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned ILEN = 32
) ();

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [ILEN-1:0] in_inst;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [ILEN-1:0] out_inst;

   modport slave (
      input  in_valid, in_pc, in_inst, flush, out_ready,
      output in_ready, out_valid, out_pc, out_inst
   );

   modport master (
      output in_valid, in_pc, in_inst, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_inst
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   // Next count: clear wins, otherwise step unless already all-ones
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID elastic pipeline stage: main register drives decode, skid register
// absorbs one extra entry so in_ready can be a flop.
// Optional build macro IF_ID_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
module if_id_skid_stage
   import if_id_pkg::*;
#(
   parameter int unsigned    XLEN     = XLEN_DEF,
   parameter int unsigned    ILEN     = ILEN_DEF,
   parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_INST_DEF)
) (
   input  logic                 clk,
   input  logic                 reset,
   if_id_skid_stage_if.slave    bus
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          flush_cnt
`endif
);

   state_e          state_q, state_d;
   logic            in_ready_q;
   logic [XLEN-1:0] main_pc_q, skid_pc_q;
   logic [ILEN-1:0] main_inst_q, skid_inst_q;

   logic fire_in, fire_out, out_valid;
   logic load_main_in, load_main_skid, load_skid;

   assign out_valid = (state_q != StEmpty);
   assign fire_in   = bus.in_valid & in_ready_q;
   assign fire_out  = out_valid & bus.out_ready;

   // State register; in_ready is precomputed from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != StFull);
      end
   end

   // Next-state: occupancy follows fire_in/fire_out, flush empties
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: if (fire_in) state_d = StOne;
            StOne: begin
               if (fire_in && !fire_out)      state_d = StFull;
               else if (fire_out && !fire_in) state_d = StEmpty;
            end
            StFull:  if (fire_out) state_d = StOne;
            default: state_d = StEmpty;
         endcase
      end
   end

   // Outputs and datapath load enables
   always_comb begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (!bus.flush) begin
         unique case (state_q)
            StEmpty: load_main_in = fire_in;
            StOne: begin
               load_main_in = fire_in & fire_out;
               load_skid    = fire_in & ~fire_out;
            end
            StFull:  load_main_skid = fire_out;
            default: ;
         endcase
      end
      bus.in_ready  = in_ready_q;
      bus.out_valid = out_valid;
      // Never expose stale data when empty
      bus.out_pc    = out_valid ? main_pc_q : '0;
      bus.out_inst  = out_valid ? main_inst_q : NOP_INST;
   end

   // Main and skid data registers
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         main_pc_q   <= '0;
         main_inst_q <= NOP_INST;
         skid_pc_q   <= '0;
         skid_inst_q <= NOP_INST;
      end else begin
         if (load_main_in) begin
            main_pc_q   <= bus.in_pc;
            main_inst_q <= bus.in_inst;
         end else if (load_main_skid) begin
            main_pc_q   <= skid_pc_q;
            main_inst_q <= skid_inst_q;
         end
         if (load_skid) begin
            skid_pc_q   <= bus.in_pc;
            skid_inst_q <= bus.in_inst;
         end
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   sat_counter #(
      .WIDTH (32)
   ) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (out_valid & ~bus.out_ready),
      .count (stall_cnt)
   );

   sat_counter #(
      .WIDTH (32)
   ) u_flush_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (bus.flush & out_valid),
      .count (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: a 2-deep queue model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_id_skid_stage;
   import if_id_pkg::*;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset;
   bit   chk_en = 1'b0;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   if_id_skid_stage_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   if_id_skid_stage #(
      .XLEN     (XLEN),
      .ILEN     (ILEN),
      .NOP_INST (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a FIFO of capacity 2 whose ready reflects post-edge room
   entry_t      mq[$];
   bit          m_rdy = 1'b1;
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;

   always @(posedge clk) begin
      bit acc;
      if (reset) begin
         mq.delete();
         m_rdy   = 1'b1;
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (mq.size() > 0 && !bus.out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (bus.flush) begin
            if (mq.size() > 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
            mq.delete();
         end else begin
            acc = bus.in_valid && m_rdy;
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            if (acc) mq.push_back(entry_t'{pc: bus.in_pc, inst: bus.in_inst});
         end
         m_rdy = (mq.size() < 2);
      end
   end

   // Compare DUT against model mid-cycle
   always @(negedge clk) begin
      logic        e_valid;
      logic [63:0] e_pc;
      logic [31:0] e_inst;
      if (chk_en) begin
         e_valid = (mq.size() != 0);
         if (e_valid) begin
            e_pc   = mq[0].pc;
            e_inst = mq[0].inst;
         end else begin
            e_pc   = '0;
            e_inst = NOP;
         end
         check("out_valid", 64'(bus.out_valid), 64'(e_valid));
         check("out_pc", bus.out_pc, e_pc);
         check("out_inst", 64'(bus.out_inst), 64'(e_inst));
         check("in_ready", 64'(bus.in_ready), 64'(m_rdy));
`ifdef IF_ID_PERF_CNT_EN
         check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
         check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [63:0] pc);
      bus.in_valid = 1'b1;
      bus.in_pc    = pc;
      bus.in_inst  = 32'h0050_0093 ^ pc[31:0];
   endtask

   initial begin
      bit          rdy_at_offer;
      bit          pending;
      int unsigned rdy_pct;

      bus.in_valid  = 1'b0;
      bus.in_pc     = '0;
      bus.in_inst   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      tick();
      tick();
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset then idle
      tick();
      tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_inst", 64'(bus.out_inst), 64'h13);
      check("rst_out_pc", bus.out_pc, 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Streaming at full rate, one-cycle latency
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer(64'h1000 + 64'(4 * i));
         tick();
         check("stream_valid", 64'(bus.out_valid), 64'd1);
         check("stream_pc", bus.out_pc, 64'h1000 + 64'(4 * i));
         check("stream_ready", 64'(bus.in_ready), 64'd1);
      end
      bus.in_valid = 1'b0;
      tick();
      check("stream_drained", 64'(bus.out_valid), 64'd0);

      // Backpressure fills both entries, then drains in order
      bus.out_ready = 1'b0;
      offer(64'h2000);
      tick();
      check("bp1_ready", 64'(bus.in_ready), 64'd1);
      check("bp1_pc", bus.out_pc, 64'h2000);
      offer(64'h2004);
      tick();
      check("bp_full_ready", 64'(bus.in_ready), 64'd0);
      check("bp_full_pc", bus.out_pc, 64'h2000);
      bus.in_valid = 1'b0;
      tick();
      check("bp_hold_pc", bus.out_pc, 64'h2000);
      bus.out_ready = 1'b1;
      tick();
      check("bp_second_pc", bus.out_pc, 64'h2004);
      check("bp_second_ready", 64'(bus.in_ready), 64'd1);
      tick();
      check("bp_empty", 64'(bus.out_valid), 64'd0);

      // Flush from FULL with an input offered
      bus.out_ready = 1'b0;
      offer(64'h2100);
      tick();
      offer(64'h2104);
      tick();
      offer(64'h3000);
      bus.flush = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_valid", 64'(bus.out_valid), 64'd0);
      check("flush_inst", 64'(bus.out_inst), 64'h13);
      check("flush_pc", bus.out_pc, 64'd0);
      check("flush_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      repeat (3) begin
         tick();
         check("flush_stays_empty", 64'(bus.out_valid), 64'd0);
      end

`ifdef IF_ID_PERF_CNT_EN
      // Counters: five stalled cycles, one flush while occupied, then reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("perf_rst_stall", 64'(stall_cnt), 64'd0);
      check("perf_rst_flush", 64'(flush_cnt), 64'd0);
      bus.out_ready = 1'b0;
      offer(64'h4000);
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      check("perf_stall5", 64'(stall_cnt), 64'd5);
      check("perf_flush1", 64'(flush_cnt), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("perf_clr_stall", 64'(stall_cnt), 64'd0);
      check("perf_clr_flush", 64'(flush_cnt), 64'd0);
`endif

      // Random traffic; an unaccepted offer is held until taken or flushed
      rdy_at_offer = 1'b1;
      rdy_pct      = 90;
      for (int c = 0; c < 3000; c++) begin
         if (c % 256 == 0) rdy_pct = (c % 768 == 0) ? 90 : ((c % 768 == 256) ? 50 : 20);
         pending = bus.in_valid && !rdy_at_offer && !bus.flush && !reset;
         reset     = ($urandom_range(0, 199) == 0);
         bus.flush = ($urandom_range(0, 31) == 0);
         if (!pending) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_pc    = {$urandom(), $urandom()};
            bus.in_inst  = $urandom();
         end
         bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
         rdy_at_offer  = bus.in_ready;
         tick();
      end

      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
Parametrised IF/ID pipeline stage that replaces the bare fetch/decode latch with an elastic register.
- Valid/ready handshake on both sides.
- 2-entry skid buffer, so upstream ready is fully registered.
- Synchronous flush that inserts a NOP bubble.
- Sits between the fetch unit (PC + instruction memory) and the decoder/register-file read stage.

Parameters:
XLEN, 64, PC width in bits.
ILEN, 32, instruction width in bits.
NOP_INST, 32'h0000_0013, encoding driven on out_inst whenever the stage holds no valid entry (ADDI x0,x0,0).

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  fetch presents a valid PC/instruction pair.
in_ready  output  1  stage can accept; registered, never combinationally dependent on out_ready.
in_pc  input  XLEN  fetched PC.
in_inst  input  ILEN  fetched instruction.
flush  input  1  discard all held entries (branch mispredict / exception).
out_valid  output  1  out_pc/out_inst hold a valid entry.
out_ready  input  1  decode accepts the entry this cycle.
out_pc  output  XLEN  PC of the head entry.
out_inst  output  ILEN  instruction of the head entry; NOP_INST when out_valid=0.

Behaviour:
- Handshake:
  - fire_in = in_valid & in_ready.
  - fire_out = out_valid & out_ready.
  - Upstream must hold in_pc/in_inst stable while in_valid=1 and in_ready=0.
- Storage: main register (drives outputs) plus skid register.
- State machine: EMPTY, ONE, FULL.
  - EMPTY: out_valid=0, in_ready=1. fire_in -> ONE, main<=input.
  - ONE:
    - fire_in & !fire_out -> FULL, skid<=input.
    - fire_out & !fire_in -> EMPTY.
    - fire_in & fire_out -> ONE, main<=input.
    - Neither -> hold.
  - FULL: in_ready=0. fire_out -> ONE, main<=skid. Otherwise hold.
- in_ready is registered and equals (next_state != FULL).
- Latency: EMPTY stage presents an accepted entry on out_* the cycle after fire_in.
  - Sustained throughput 1 entry/cycle with out_ready=1.
- Ordering: strict FIFO; entries are never reordered, duplicated or dropped except by flush/reset.
- Flush:
  - Next state is EMPTY regardless of current state.
  - An input offered in the flush cycle is dropped even if in_ready=1.
  - out_ready in the flush cycle is ignored for state purposes; the entry shown that cycle counts as consumed if out_ready=1.
  - Next cycle: out_valid=0, out_inst=NOP_INST, out_pc=0, in_ready=1.
- Reset:
  - State EMPTY, out_valid=0, out_pc=0, out_inst=NOP_INST, in_ready=1 on the cycle after reset.
  - Skid contents cleared to 0/NOP_INST.
  - Reset mid-operation discards all entries identically to flush.
  - Reset has priority over flush.
- Invalid outputs: when out_valid=0, out_pc=0 and out_inst=NOP_INST, never stale data.
- Widths: no arithmetic on data; the parameters only size the registers.

Optional Feature:
Macro IF_ID_PERF_CNT_EN.
- With it:
  - Extra output stall_cnt [31:0] counts cycles with out_valid=1 & out_ready=0.
  - Extra output flush_cnt [31:0] counts cycles with flush=1 while state!=EMPTY.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset, not on flush.
- Without it: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package if_id_pkg:
  - State enum typedef (EMPTY/ONE/FULL, 2-bit).
  - Default NOP_INST constant.
  - Packed struct typedef {pc, inst} parametrised via localparams XLEN_DEF=64, ILEN_DEF=32.
- One natural sub-module: sat_counter (WIDTH param, clear, inc, saturating).
  - Instantiated twice, only under IF_ID_PERF_CNT_EN.
- Main/skid datapath stays inline.

Test Plan:
- Reset then idle -> out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1.
- Stream PC 0x1000,0x1004,0x1008 with out_ready=1 -> same PCs on out_pc on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Send 0x2000,0x2004 with out_ready=0 -> state FULL, in_ready=0, out_pc=0x2000 held; raise out_ready -> 0x2000 then 0x2004, in order, no loss.
- In FULL, assert flush with in_valid=1 (PC 0x3000) -> next cycle out_valid=0, out_inst=NOP_INST, in_ready=1; 0x3000 never appears.
- Simultaneous fire_in/fire_out in ONE over 8 cycles of random backpressure -> output sequence equals input sequence exactly (scoreboard).
- With IF_ID_PERF_CNT_EN: 5 backpressure cycles, then flush while non-empty -> stall_cnt=5, flush_cnt=1; reset clears both.
